// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared opcodes, widths and request payload for the sequenced divider.
//   DIV_OP_* : divider operation encodings (RV32M DIV/DIVU/REM/REMU)
//   ALU_*    : shared ALU opcode encodings driven on alu_op_o
package div_seq_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DIV_OP_W = 2;
   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned CNT_W    = 5;

   localparam logic [DIV_OP_W-1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [DIV_OP_W-1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [DIV_OP_W-1:0] DIV_OP_REM  = 2'b10;
   localparam logic [DIV_OP_W-1:0] DIV_OP_REMU = 2'b11;

   localparam logic [ALU_OP_W-1:0] ALU_NONE = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd8;

   typedef struct packed {
      logic [DIV_OP_W-1:0] op;
      logic [XLEN-1:0]     a;
      logic [XLEN-1:0]     b;
   } div_req_t;

   // DIV and REM are signed; the low opcode bit marks the unsigned variants
   function automatic logic op_is_signed(input logic [DIV_OP_W-1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input logic [DIV_OP_W-1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU/REM/REMU sequencer built on the shared ALU.
// Restoring division, one ALU_SUB per quotient bit; signs handled by ALU negation.
//   clk_i, rst_ni                 : clock, async active-low reset
//   req_valid_i/req_ready_o       : request handshake (ready only when idle)
//   req_op_i, req_a_i, req_b_i    : operation, dividend, divisor
//   resp_valid_o/resp_ready_i     : response handshake, resp_data_o held until taken
//   alu_op_o, alu_a_o, alu_b_o    : shared ALU command (derived from registered state)
//   alu_out_i                     : shared ALU result, same cycle
module div_seq
   import div_seq_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [DIV_OP_W-1:0] req_op_i,
   input  logic [XLEN-1:0]     req_a_i,
   input  logic [XLEN-1:0]     req_b_i,
   output logic                resp_valid_o,
   input  logic                resp_ready_i,
   output logic [XLEN-1:0]     resp_data_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic [XLEN-1:0]     alu_a_o,
   output logic [XLEN-1:0]     alu_b_o,
   input  logic [XLEN-1:0]     alu_out_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_NEG_A, S_NEG_B, S_CALC, S_NEG_R, S_DONE
   } state_e;

   localparam logic [XLEN-1:0]  INT_MIN  = XLEN'(32'h8000_0000);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

   state_e           r_state, w_state_nxt;
   logic             r_rem, w_rem_nxt;
   logic             r_a_neg, w_a_neg_nxt;
   logic             r_b_neg, w_b_neg_nxt;
   logic [XLEN-1:0]  r_r, w_r_nxt;
   logic [XLEN-1:0]  r_q, w_q_nxt;
   logic [XLEN-1:0]  r_b, w_b_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_ready, r_valid;
   logic [XLEN-1:0]  r_data, w_data_nxt;

   div_req_t         w_req;
   logic             w_req_signed;
   logic             w_req_a_neg, w_req_b_neg;
   logic [XLEN-1:0]  w_p;
   logic             w_s, w_borrow, w_no_borrow;
   logic [XLEN-1:0]  w_r_step, w_q_step;
   logic             w_need_neg_r;

   assign w_req        = '{op: req_op_i, a: req_a_i, b: req_b_i};
   assign w_req_signed = op_is_signed(w_req.op);
   assign w_req_a_neg  = w_req_signed & w_req.a[XLEN-1];
   assign w_req_b_neg  = w_req_signed & w_req.b[XLEN-1];

   // One restoring step: bit shifted out of R makes the 33-bit partial always >= |b|
   assign w_p         = {r_r[XLEN-2:0], r_q[XLEN-1]};
   assign w_s         = r_r[XLEN-1];
   assign w_borrow    = (~w_p[XLEN-1] & r_b[XLEN-1]) |
                        (~(w_p[XLEN-1] ^ r_b[XLEN-1]) & alu_out_i[XLEN-1]);
   assign w_no_borrow = w_s | ~w_borrow;
   assign w_r_step    = w_no_borrow ? alu_out_i : w_p;
   assign w_q_step    = {r_q[XLEN-2:0], w_no_borrow};

   // Quotient negative when signs differ; remainder takes the dividend's sign
   assign w_need_neg_r = r_rem ? r_a_neg : (r_a_neg ^ r_b_neg);

   // ALU command from the current state
   always_comb begin
      alu_op_o = ALU_NONE;
      alu_a_o  = '0;
      alu_b_o  = '0;
      case (r_state)
         S_NEG_A: begin alu_op_o = ALU_SUB; alu_b_o = r_q; end
         S_NEG_B: begin alu_op_o = ALU_SUB; alu_b_o = r_b; end
         S_CALC:  begin alu_op_o = ALU_SUB; alu_a_o = w_p; alu_b_o = r_b; end
         S_NEG_R: begin alu_op_o = ALU_SUB; alu_b_o = r_rem ? r_r : r_q; end
         default: ;
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_a_neg_nxt = r_a_neg;
      w_b_neg_nxt = r_b_neg;
      w_r_nxt     = r_r;
      w_q_nxt     = r_q;
      w_b_nxt     = r_b;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i) begin
               w_rem_nxt   = op_is_rem(w_req.op);
               w_a_neg_nxt = w_req_a_neg;
               w_b_neg_nxt = w_req_b_neg;
               w_q_nxt     = w_req.a;
               w_b_nxt     = w_req.b;
               w_r_nxt     = '0;
               w_cnt_nxt   = '0;
               if (w_req.b == '0) begin
                  w_data_nxt  = op_is_rem(w_req.op) ? w_req.a : '1;
                  w_state_nxt = S_DONE;
               end else if (w_req_signed && w_req.a == INT_MIN && w_req.b == '1) begin
                  w_data_nxt  = op_is_rem(w_req.op) ? '0 : INT_MIN;
                  w_state_nxt = S_DONE;
               end else if (w_req_a_neg) begin
                  w_state_nxt = S_NEG_A;
               end else if (w_req_b_neg) begin
                  w_state_nxt = S_NEG_B;
               end else begin
                  w_state_nxt = S_CALC;
               end
            end
         end
         S_NEG_A: begin
            w_q_nxt     = alu_out_i;
            w_state_nxt = r_b_neg ? S_NEG_B : S_CALC;
         end
         S_NEG_B: begin
            w_b_nxt     = alu_out_i;
            w_state_nxt = S_CALC;
         end
         S_CALC: begin
            w_r_nxt   = w_r_step;
            w_q_nxt   = w_q_step;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
               if (w_need_neg_r) begin
                  w_state_nxt = S_NEG_R;
               end else begin
                  w_data_nxt  = r_rem ? w_r_step : w_q_step;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_NEG_R: begin
            w_data_nxt  = alu_out_i;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (resp_ready_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_rem   <= 1'b0;
         r_a_neg <= 1'b0;
         r_b_neg <= 1'b0;
         r_r     <= '0;
         r_q     <= '0;
         r_b     <= '0;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_a_neg <= w_a_neg_nxt;
         r_b_neg <= w_b_neg_nxt;
         r_r     <= w_r_nxt;
         r_q     <= w_q_nxt;
         r_b     <= w_b_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_valid <= (w_state_nxt == S_DONE);
         r_data  <= w_data_nxt;
      end
   end

   assign req_ready_o  = r_ready;
   assign resp_valid_o = r_valid;
   assign resp_data_o  = r_data;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: bench for div_seq with a behavioural ALU and an arithmetic reference model.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [1:0]  req_op_i = '0;
   logic [31:0] req_a_i = '0;
   logic [31:0] req_b_i = '0;
   logic        resp_valid_o;
   logic        resp_ready_i = 1'b0;
   logic [31:0] resp_data_o;
   logic [3:0]  alu_op_o;
   logic [31:0] alu_a_o, alu_b_o, alu_out_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   // Shared ALU as the parent would provide it
   always_comb begin
      case (alu_op_o)
         ALU_ADD: alu_out_i = alu_a_o + alu_b_o;
         ALU_SUB: alu_out_i = alu_a_o - alu_b_o;
         default: alu_out_i = 32'h0;
      endcase
   end

   div_seq dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op_i(req_op_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_out_i(alu_out_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit is_signed_op(input logic [1:0] op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic bit is_rem_op(input logic [1:0] op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // RISC-V M-extension result from plain integer arithmetic
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      if (b == 32'h0) return is_rem_op(op) ? a : 32'hFFFF_FFFF;
      if (is_signed_op(op) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return is_rem_op(op) ? 32'h0 : 32'h8000_0000;
      if (is_signed_op(op)) begin
         sa = $signed(a);
         sb = $signed(b);
         return is_rem_op(op) ? 32'(sa % sb) : 32'(sa / sb);
      end
      return is_rem_op(op) ? a % b : a / b;
   endfunction

   // Edges after the accepting edge until resp_valid_o is seen
   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bit an, bn, nr;
      if (is_special(op, a, b)) return 0;
      an = is_signed_op(op) && a[31];
      bn = is_signed_op(op) && b[31];
      nr = is_rem_op(op) ? an : (an != bn);
      return 32 + int'(an) + int'(bn) + int'(nr);
   endfunction

   // Issue one request, wait for the response, hold it for 'hold' cycles, then accept it
   task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] data, output int lat,
                         output bit alu_busy, output bit hs_bad, output bit hold_bad);
      hs_bad = 0; hold_bad = 0; alu_busy = 0; lat = -1;
      @(negedge clk_i);
      req_op_i = op; req_a_i = a; req_b_i = b; req_valid_i = 1'b1;
      if (!req_ready_o) hs_bad = 1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (alu_op_o != ALU_NONE) alu_busy = 1;
         if (req_ready_o) hs_bad = 1;
         if (resp_valid_o) begin lat = k; break; end
         @(posedge clk_i); #1;
      end
      data = resp_data_o;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk_i); #1;
         if (resp_data_o !== data || !resp_valid_o || req_ready_o || alu_op_o != ALU_NONE)
            hold_bad = 1;
      end
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      if (resp_valid_o || !req_ready_o) hs_bad = 1;
   endtask

   task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input int exp_l, input int hold);
      logic [31:0] d;
      int l;
      bit busy, hsb, hb;
      do_req(op, a, b, hold, d, l, busy, hsb, hb);
      chk({name, " data"}, d, exp_d);
      chk({name, " latency"}, 32'(l), 32'(exp_l));
      chk({name, " alu_used"}, 32'(busy), 32'(exp_l != 0));
      chk({name, " handshake"}, 32'(hsb), 32'd0);
      if (hold > 0) chk({name, " hold_stable"}, 32'(hb), 32'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         4: return 32'(-int'($urandom_range(1, 20)));
         default: return $urandom();
      endcase
   endfunction

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_d;
      int          exp_l;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [31:0] d, ra, rb;
      logic [1:0]  rop;
      int          l;
      bit          bad;

      vecs[0]  = '{"divu_100_7",   DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         32};
      vecs[1]  = '{"remu_100_7",   DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          32};
      vecs[2]  = '{"div_m7_2",     DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
      vecs[3]  = '{"rem_m7_2",     DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
      vecs[4]  = '{"divu_5_0",     DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
      vecs[5]  = '{"remu_5_0",     DIV_OP_REMU, 32'd5,          32'd0,          32'd5,          0};
      vecs[6]  = '{"div_ovf",      DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
      vecs[7]  = '{"rem_ovf",      DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
      vecs[8]  = '{"div_7_m2",     DIV_OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
      vecs[9]  = '{"rem_7_m2",     DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
      vecs[10] = '{"div_m7_m2",    DIV_OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          34};
      vecs[11] = '{"rem_m7_m2",    DIV_OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  35};
      vecs[12] = '{"div_0_5",      DIV_OP_DIV,  32'd0,          32'd5,          32'd0,          32};
      vecs[13] = '{"divu_max_max", DIV_OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32};
      vecs[14] = '{"div_5_0",      DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0};
      vecs[15] = '{"rem_m5_0",     DIV_OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0};

      // Reset state
      #12;
      chk("rst ready", 32'(req_ready_o), 32'd1);
      chk("rst valid", 32'(resp_valid_o), 32'd0);
      chk("rst data", resp_data_o, 32'd0);
      chk("rst alu_op", 32'(alu_op_o), 32'(ALU_NONE));
      chk("rst alu_ab", alu_a_o | alu_b_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (vecs[i])
         run_one(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_l, i % 3);

      // Backpressure with a second request waiting behind the response
      @(negedge clk_i);
      req_op_i = DIV_OP_DIVU; req_a_i = 32'hFFFF_FFFF; req_b_i = 32'd1; req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      l = -1;
      for (int k = 0; k < 100; k++) begin
         if (resp_valid_o) begin l = k; break; end
         @(posedge clk_i); #1;
      end
      chk("bp latency", 32'(l), 32'd32);
      d = resp_data_o;
      chk("bp data", d, 32'hFFFF_FFFF);
      req_op_i = DIV_OP_DIVU; req_a_i = 32'd9; req_b_i = 32'd3; req_valid_i = 1'b1;
      bad = 0;
      for (int h = 0; h < 5; h++) begin
         @(posedge clk_i); #1;
         if (resp_data_o !== d || !resp_valid_o || req_ready_o || alu_op_o != ALU_NONE) bad = 1;
      end
      chk("bp frozen", 32'(bad), 32'd0);
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;
      chk("bp ready after hs", 32'(req_ready_o), 32'd1);
      chk("bp valid after hs", 32'(resp_valid_o), 32'd0);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("bp second accepted", 32'(req_ready_o), 32'd0);
      l = -1;
      for (int k = 0; k < 100; k++) begin
         if (resp_valid_o) begin l = k; break; end
         @(posedge clk_i); #1;
      end
      chk("bp second latency", 32'(l), 32'd32);
      chk("bp second data", resp_data_o, 32'd3);
      resp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      resp_ready_i = 1'b0;

      // Reset in the middle of CALC
      @(negedge clk_i);
      req_op_i = DIV_OP_DIVU; req_a_i = 32'd100; req_b_i = 32'd7; req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      chk("midrst valid", 32'(resp_valid_o), 32'd0);
      chk("midrst ready", 32'(req_ready_o), 32'd1);
      chk("midrst alu_op", 32'(alu_op_o), 32'(ALU_NONE));
      chk("midrst alu_ab", alu_a_o | alu_b_o, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_one("after_rst_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 32, 0);

      // Randomized requests against the reference model
      for (int n = 0; n < 150; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = pick();
         run_one($sformatf("rand%0d op%0d %h/%h", n, rop, ra, rb), rop, ra, rb,
                 ref_res(rop, ra, rb), ref_lat(rop, ra, rb), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
